// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write controller for the control register bank.
//
// Two requesters (A = SPI host path, B = on-chip sequencer) issue writes with
// a valid/ready handshake. Grants alternate on ties; out-of-range writes are
// dropped and flagged on err/err_src.
//
// Build option: define REG_ARB_SHADOW_EN to stage writes in shadow registers
// that are copied to the active registers on a commit strobe. Without it,
// writes land directly in the active registers and commit is ignored.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   requester A write channel
//   b_valid/b_ready/b_addr/b_data   requester B write channel
//   commit                   single-cycle commit strobe
//   reg_0x00..reg_0x04       active register values
//   err, err_src             one-cycle dropped-write pulse and its requester
//   commit_pending           commit requested but not yet applied
module reg_write_arbiter #(
    parameter int unsigned W        = 8,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned NUM_REGS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [W-1:0]      a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [W-1:0]      b_data,
    input  logic              commit,
    output logic [W-1:0]      reg_0x00,
    output logic [W-1:0]      reg_0x01,
    output logic [W-1:0]      reg_0x02,
    output logic [W-1:0]      reg_0x03,
    output logic [W-1:0]      reg_0x04,
    output logic              err,
    output logic              err_src,
    output logic              commit_pending
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    state_t            state;
    logic              last_grant;
    logic [ADDR_W-1:0] lat_addr;
    logic [W-1:0]      lat_data;
    logic              lat_src;
    logic [W-1:0]      active [NUM_REGS];

    logic              in_range;
    logic              commit_block;
    logic              grant_a;
    logic              grant_b;

`ifdef REG_ARB_SHADOW_EN
    logic [W-1:0]      shadow [NUM_REGS];
    logic              pending;

    // A fresh or pending commit pre-empts arbitration in IDLE.
    assign commit_block   = commit | pending;
    assign commit_pending = pending;
`else
    logic              unused_commit;

    assign unused_commit  = commit;
    assign commit_block   = 1'b0;
    assign commit_pending = 1'b0;
`endif

    // Full-width unsigned compare: upper address bits never alias.
    assign in_range = (lat_addr < ADDR_W'(NUM_REGS));

    // Round-robin grant; ready is combinational and only ever high in IDLE.
    assign grant_a = !rst && (state == IDLE) && !commit_block && a_valid &&
                     (!b_valid || (last_grant == SRC_B));
    assign grant_b = !rst && (state == IDLE) && !commit_block && b_valid &&
                     (!a_valid || (last_grant == SRC_A));

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Controller state, latched request, register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SRC_B;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_src    <= SRC_A;
            err        <= 1'b0;
            err_src    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                active[i] <= '0;
            end
`ifdef REG_ARB_SHADOW_EN
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
            pending    <= 1'b0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit_block) begin
                        state <= COMMIT;
                    end else if (grant_a) begin
                        lat_addr   <= a_addr;
                        lat_data   <= a_data;
                        lat_src    <= SRC_A;
                        last_grant <= SRC_A;
                        state      <= WRITE;
                    end else if (grant_b) begin
                        lat_addr   <= b_addr;
                        lat_data   <= b_data;
                        lat_src    <= SRC_B;
                        last_grant <= SRC_B;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (in_range) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (lat_addr == ADDR_W'(i)) begin
`ifdef REG_ARB_SHADOW_EN
                                shadow[i] <= lat_data;
`else
                                active[i] <= lat_data;
`endif
                            end
                        end
                    end else begin
                        err     <= 1'b1;
                        err_src <= lat_src;
                    end
`ifdef REG_ARB_SHADOW_EN
                    // Commit arriving mid-write is deferred; this write is included.
                    if (commit) begin
                        pending <= 1'b1;
                    end
`endif
                    state <= IDLE;
                end
                COMMIT: begin
`ifdef REG_ARB_SHADOW_EN
                    for (int i = 0; i < NUM_REGS; i++) begin
                        active[i] <= shadow[i];
                    end
                    // A commit seen during COMMIT schedules another one.
                    pending <= commit;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign reg_0x00 = active[0];
    assign reg_0x01 = active[1];
    assign reg_0x02 = active[2];
    assign reg_0x03 = active[3];
    assign reg_0x04 = active[4];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed by
// randomized two-requester traffic checked against a transaction-level model.
module tb_reg_write_arbiter;

    localparam int unsigned W        = 8;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned NUM_REGS = 5;
`ifdef REG_ARB_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [W-1:0]      a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [W-1:0]      b_data;
    logic              commit;
    logic [W-1:0]      reg_0x00, reg_0x01, reg_0x02, reg_0x03, reg_0x04;
    logic              err;
    logic              err_src;
    logic              commit_pending;

    reg_write_arbiter #(.W(W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .commit(commit),
        .reg_0x00(reg_0x00), .reg_0x01(reg_0x01), .reg_0x02(reg_0x02),
        .reg_0x03(reg_0x03), .reg_0x04(reg_0x04),
        .err(err), .err_src(err_src), .commit_pending(commit_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] dut_regs [NUM_REGS];
    always_comb begin
        dut_regs[0] = reg_0x00;
        dut_regs[1] = reg_0x01;
        dut_regs[2] = reg_0x02;
        dut_regs[3] = reg_0x03;
        dut_regs[4] = reg_0x04;
    end

    int checks = 0;
    int errors = 0;

    // Reference register model: what software should observe.
    logic [W-1:0] act_m [NUM_REGS];
    logic [W-1:0] sh_m  [NUM_REGS];

    typedef struct {
        int              at;
        logic [ADDR_W-1:0] addr;
        logic [W-1:0]    data;
        logic            src;
    } ev_t;
    ev_t evq[$];

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            act_m[i] = '0;
            sh_m[i]  = '0;
        end
    endfunction

    function automatic void model_write(input int a, input logic [W-1:0] d);
        if (SHADOW) sh_m[a] = d;
        else        act_m[a] = d;
    endfunction

    function automatic void model_commit();
        if (SHADOW) begin
            for (int i = 0; i < NUM_REGS; i++) act_m[i] = sh_m[i];
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), 32'(dut_regs[i]), 32'(act_m[i]));
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 3) != 0) return ADDR_W'($urandom_range(0, NUM_REGS - 1));
        return ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int grant_at;
        int free_at;
        bit last_a;
        bit a_req, b_req;
        bit exp_ga, exp_gb, exp_err, exp_src;
        logic [ADDR_W-1:0] ra_addr, rb_addr;
        logic [W-1:0] ra_data, rb_data;
        int na, nb;

        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0; commit = 1'b0;
        model_reset();

        // ---- reset: ready held low, then reset values
        next();
        mid();
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        next();
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        mid();
        chk_regs("rst");
        chk("rst_err", err, 0);
        chk("rst_err_src", err_src, 0);
        chk("rst_pending", commit_pending, 0);

        // ---- single write A: 0x02 <- 0xA5
        next();
        a_valid = 1'b1; a_addr = 7'h02; a_data = 8'hA5;
        mid();
        chk("t1_a_ready", a_ready, 1);
        chk("t1_b_ready", b_ready, 0);
        next();
        a_valid = 1'b0;
        mid();
        chk("t1_write_a_ready", a_ready, 0);
        chk_regs("t1_write");
        next();
        model_write(2, 8'hA5);
        mid();
        chk_regs("t1_t2");
        next();
        commit = 1'b1;
        mid();
        next();
        commit = 1'b0;
        mid();
        chk_regs("t1_commit_cycle");
        next();
        model_commit();
        mid();
        chk_regs("t1_after_commit");

        // ---- round-robin tie after reset: A, B, A, B every 2 cycles
        next();
        rst = 1'b1;
        mid();
        next();
        rst = 1'b0;
        model_reset();
        na = 0; nb = 0;
        a_valid = 1'b1; a_addr = 7'h00; a_data = 8'h10;
        b_valid = 1'b1; b_addr = 7'h01; b_data = 8'h20;
        for (int k = 0; k < 8; k++) begin
            exp_ga = (k % 4 == 0);
            exp_gb = (k % 4 == 2);
            mid();
            chk($sformatf("rr_a_ready_c%0d", k), a_ready, exp_ga);
            chk($sformatf("rr_b_ready_c%0d", k), b_ready, exp_gb);
            next();
            if (exp_ga) begin na++; a_data = 8'(8'h10 + na); end
            if (exp_gb) begin nb++; b_data = 8'(8'h20 + nb); end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        model_write(0, 8'h11);
        model_write(1, 8'h21);
        mid();
        chk_regs("rr_final");

        // ---- out-of-range: B 0x05 <- 0xFF, then A 0x44 <- 0x11
        next();
        b_valid = 1'b1; b_addr = 7'h05; b_data = 8'hFF;
        mid();
        chk("oor_b_ready", b_ready, 1);
        chk("oor_err0", err, 0);
        next();
        b_valid = 1'b0;
        mid();
        chk("oor_err1", err, 0);
        next();
        a_valid = 1'b1; a_addr = 7'h44; a_data = 8'h11;
        mid();
        chk("oor_err_b", err, 1);
        chk("oor_err_src_b", err_src, 1);
        chk("oor_a_ready", a_ready, 1);
        next();
        a_valid = 1'b0;
        mid();
        chk("oor_err_gap", err, 0);
        next();
        mid();
        chk("oor_err_a", err, 1);
        chk("oor_err_src_a", err_src, 0);
        chk_regs("oor");
        next();
        mid();
        chk("oor_err_end", err, 0);

        // ---- commit during WRITE of 0x04 <- 0x7F
        next();
        a_valid = 1'b1; a_addr = 7'h04; a_data = 8'h7F;
        mid();
        chk("cw_a_ready", a_ready, 1);
        next();
        a_valid = 1'b0; commit = 1'b1;
        mid();
        chk("cw_pending_write", commit_pending, 0);
        next();
        commit = 1'b0;
        model_write(4, 8'h7F);
        mid();
        chk("cw_pending_idle", commit_pending, SHADOW);
        chk_regs("cw_idle");
        next();
        mid();
        chk("cw_pending_commit", commit_pending, SHADOW);
        chk_regs("cw_commit_cycle");
        next();
        model_commit();
        mid();
        chk("cw_pending_done", commit_pending, 0);
        chk_regs("cw_done");

        // ---- commit and request together in IDLE: commit wins
        next();
        commit = 1'b1; a_valid = 1'b1; a_addr = 7'h03; a_data = 8'h5A;
        grant_at = SHADOW ? 2 : 0;
        for (int k = 0; k <= grant_at; k++) begin
            if (k > 0) begin
                next();
                commit = 1'b0;
            end
            mid();
            chk($sformatf("cr_a_ready_c%0d", k), a_ready, (k == grant_at));
        end
        model_commit();
        next();
        a_valid = 1'b0; commit = 1'b0;
        mid();
        next();
        model_write(3, 8'h5A);
        mid();
        chk_regs("cr_done");

        // ---- reset during WRITE of 0x01 <- 0x3C with a commit requested
        next();
        a_valid = 1'b1; a_addr = 7'h01; a_data = 8'h3C;
        mid();
        chk("mr_a_ready", a_ready, 1);
        next();
        commit = 1'b1; rst = 1'b1; b_valid = 1'b1; b_addr = 7'h02; b_data = 8'h99;
        mid();
        chk("mr_rst_a_ready", a_ready, 0);
        chk("mr_rst_b_ready", b_ready, 0);
        next();
        rst = 1'b0; commit = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        model_reset();
        mid();
        chk_regs("mr_t0");
        chk("mr_pending0", commit_pending, 0);
        chk("mr_err0", err, 0);
        chk("mr_err_src0", err_src, 0);
        next();
        mid();
        chk("mr_err1", err, 0);
        chk("mr_pending1", commit_pending, 0);
        chk_regs("mr_t1");
        next();
        mid();
        chk("mr_err2", err, 0);
        chk_regs("mr_t2");

        // ---- randomized traffic vs transaction model (no commits)
        free_at = 0; last_a = 1'b0; a_req = 1'b0; b_req = 1'b0;
        ra_addr = '0; rb_addr = '0; ra_data = '0; rb_data = '0;
        evq.delete();
        for (int k = 0; k < 420; k++) begin
            next();
            if (k < 400 && !a_req && $urandom_range(0, 2) == 0) begin
                a_req = 1'b1; ra_addr = rand_addr(); ra_data = W'($urandom);
            end
            if (k < 400 && !b_req && $urandom_range(0, 2) == 0) begin
                b_req = 1'b1; rb_addr = rand_addr(); rb_data = W'($urandom);
            end
            a_valid = a_req; a_addr = ra_addr; a_data = ra_data;
            b_valid = b_req; b_addr = rb_addr; b_data = rb_data;

            exp_err = 1'b0; exp_src = 1'b0;
            while (evq.size() > 0 && evq[0].at == k) begin
                ev_t ev;
                ev = evq.pop_front();
                if (int'(ev.addr) < NUM_REGS) model_write(int'(ev.addr), ev.data);
                else begin exp_err = 1'b1; exp_src = ev.src; end
            end

            exp_ga = 1'b0; exp_gb = 1'b0;
            if (k >= free_at) begin
                if (a_req && b_req) begin
                    if (last_a) exp_gb = 1'b1;
                    else        exp_ga = 1'b1;
                end else if (a_req) exp_ga = 1'b1;
                else if (b_req)     exp_gb = 1'b1;
            end
            if (exp_ga) evq.push_back('{k + 2, ra_addr, ra_data, 1'b0});
            if (exp_gb) evq.push_back('{k + 2, rb_addr, rb_data, 1'b1});
            if (exp_ga || exp_gb) begin
                free_at = k + 2;
                last_a  = exp_ga;
            end

            mid();
            chk($sformatf("rnd_a_ready_c%0d", k), a_ready, exp_ga);
            chk($sformatf("rnd_b_ready_c%0d", k), b_ready, exp_gb);
            chk($sformatf("rnd_err_c%0d", k), err, exp_err);
            if (exp_err) chk($sformatf("rnd_err_src_c%0d", k), err_src, exp_src);
            chk_regs($sformatf("rnd_c%0d", k));
            if (exp_ga) a_req = 1'b0;
            if (exp_gb) b_req = 1'b0;
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // ---- final commit publishes staged random writes
        next();
        commit = 1'b1;
        mid();
        next();
        commit = 1'b0;
        mid();
        next();
        model_commit();
        mid();
        chk_regs("rnd_commit");
        chk("rnd_pending_end", commit_pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
